// File: rtl/zap_decode_thumb_seq_pkg.sv
// -----------------------------------------------------------------------------
// zap_decode_thumb_seq_pkg
// Shared definitions for the Thumb-to-ARM decode sequencer:
//   - Thumb opcode pattern constants used to classify a 16-bit instruction
//   - ARM condition code for "always"
//   - BL fusion FSM state encoding
//   - helper that assembles a 35-bit ARM branch word (bit34 = halfword offset)
// -----------------------------------------------------------------------------
package zap_decode_thumb_seq_pkg;

   // Thumb encodings, matched against the top bits of the 16-bit instruction
   localparam logic [3:0] T_BRANCH_COND   = 4'b1101;
   localparam logic [4:0] T_BRANCH_NOCOND = 5'b11100;
   localparam logic [4:0] T_BL_PRE        = 5'b11110;
   localparam logic [4:0] T_BL_SUF        = 5'b11111;
   localparam logic [8:0] T_BX            = 9'b010001110;

   // ARM condition codes
   localparam logic [3:0] AL = 4'b1110;

   // ARM "BX r0" template; the register field is ORed in from the Thumb word
   localparam logic [31:0] ARM_BX_BASE = 32'hE12FFF10;

   // BL fusion state: IDLE = nothing pending, HELD = prefix stored
   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } bl_state_t;

   // ARM B/BL word with the halfword-offset flag set in bit 34
   function automatic logic [34:0] arm_branch(input logic [3:0]  cond,
                                              input logic        link,
                                              input logic [23:0] offset);
      return {1'b1, 2'b00, cond, 3'b101, link, offset};
   endfunction

endpackage

// File: rtl/zap_decode_thumb_seq_bl_fuse.sv
// -----------------------------------------------------------------------------
// zap_thumb_bl_fuse
// Holds the high half of a Thumb BL (prefix) and its PC until the matching
// suffix arrives, so the pair can be emitted as one ARM BL.
// Ports:
//   i_clk, i_reset   clock, synchronous active-low reset
//   i_clear          pipeline flush: drop any held prefix
//   i_stall          downstream stall: hold everything
//   i_load           accept a prefix (IDLE -> HELD), capturing i_hi / i_pc
//   i_consume        held prefix used (suffix or orphan): HELD -> IDLE
//   o_held           a prefix is currently stored
//   o_hi, o_pc       stored prefix offset bits and prefix PC
// -----------------------------------------------------------------------------
module zap_thumb_bl_fuse
   import zap_decode_thumb_seq_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_clear,
   input  logic            i_stall,
   input  logic            i_load,
   input  logic            i_consume,
   input  logic [10:0]     i_hi,
   input  logic [PC_W-1:0] i_pc,
   output logic            o_held,
   output logic [10:0]     o_hi,
   output logic [PC_W-1:0] o_pc
);

   bl_state_t       state_q, state_d;
   logic [10:0]     hi_q, hi_d;
   logic [PC_W-1:0] pc_q, pc_d;

   // Next-state: a flush always wins and wipes the stored prefix; otherwise
   // nothing moves while the downstream stage is stalled.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      pc_d    = pc_q;
      if (i_clear) begin
         state_d = IDLE;
         hi_d    = '0;
         pc_d    = '0;
      end else if (!i_stall) begin
         if (i_load) begin
            state_d = HELD;
            hi_d    = i_hi;
            pc_d    = i_pc;
         end else if (i_consume) begin
            state_d = IDLE;
         end
      end
   end

   // State and prefix registers; reset loses any pending prefix.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q <= IDLE;
         hi_q    <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         pc_q    <= pc_d;
      end
   end

   assign o_held = (state_q == HELD);
   assign o_hi   = hi_q;
   assign o_pc   = pc_q;

endmodule

// File: rtl/zap_decode_thumb_seq.sv
// -----------------------------------------------------------------------------
// zap_decode_thumb_seq
// Converts Thumb branch instructions into ARM-format branch words one cycle
// after acceptance; ARM words pass through, other Thumb words go out raw.
// BL prefix/suffix pairs are optionally fused into a single ARM BL.
// Ports:
//   i_clk, i_reset          clock, synchronous active-low reset
//   i_instruction(_valid)   fetched word and its valid
//   i_pc                    PC of the fetched word
//   i_cpsr_ff               CPSR; bit T_BIT selects Thumb state
//   i_stall_from_decode     downstream stall
//   i_clear_from_alu        pipeline flush
//   o_stall                 combinational: upstream must hold its inputs
//   o_instruction           35-bit ARM word, bit34 = offset in halfwords
//   o_instruction_valid     registered valid
//   o_und                   registered undefined-instruction flag
//   o_pc                    registered PC of the emitted instruction
// -----------------------------------------------------------------------------
module zap_decode_thumb_seq
#(
   parameter int T_BIT   = 5,
   parameter int FUSE_BL = 1,
   parameter int PC_W    = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [31:0]     i_instruction,
   input  logic            i_instruction_valid,
   input  logic [PC_W-1:0] i_pc,
   input  logic [31:0]     i_cpsr_ff,
   input  logic            i_stall_from_decode,
   input  logic            i_clear_from_alu,
   output logic            o_stall,
   output logic [34:0]     o_instruction,
   output logic            o_instruction_valid,
   output logic            o_und,
   output logic [PC_W-1:0] o_pc
);

   import zap_decode_thumb_seq_pkg::*;

   logic            thumb;
   logic [15:0]     ins16;
   logic            is_pre;
   logic            is_suf;
   logic            held;
   logic [10:0]     held_hi;
   logic [PC_W-1:0] held_pc;
   logic            orphan;
   logic            accept;
   logic            load;
   logic            consume;
   logic            dec_emit;
   logic            dec_und;
   logic [34:0]     dec_instr;

   logic [34:0]     instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            und_q, und_d;
   logic [PC_W-1:0] pc_q, pc_d;

   logic            unused_cpsr;

   assign unused_cpsr = ^i_cpsr_ff;

   assign thumb  = i_cpsr_ff[T_BIT];
   assign ins16  = i_instruction[15:0];
   assign is_pre = thumb && (ins16[15:11] == T_BL_PRE);
   assign is_suf = thumb && (ins16[15:11] == T_BL_SUF);

   // A held prefix followed by anything but a suffix (including a drop back
   // to ARM state) is reported as undefined; the new word is stalled so it
   // is decoded on its own in the following cycle.
   assign orphan  = held && i_instruction_valid && !is_suf;
   assign o_stall = i_stall_from_decode || orphan;
   assign accept  = i_instruction_valid && !o_stall && !i_clear_from_alu;

   assign load    = accept && is_pre && (FUSE_BL != 0);
   assign consume = orphan || (accept && is_suf && held);

   zap_thumb_bl_fuse #(
      .PC_W (PC_W)
   ) u_bl_fuse (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (i_clear_from_alu),
      .i_stall   (i_stall_from_decode),
      .i_load    (load),
      .i_consume (consume),
      .i_hi      (ins16[10:0]),
      .i_pc      (i_pc),
      .o_held    (held),
      .o_hi      (held_hi),
      .o_pc      (held_pc)
   );

   // Combinational decode of the current word. Offsets are sign-extended to
   // 24 bits and left in halfword units; bit34 of the result says so.
   always_comb begin
      dec_emit  = 1'b1;
      dec_und   = 1'b0;
      dec_instr = {19'b0, ins16};
      if (!thumb) begin
         dec_instr = {3'b000, i_instruction};
      end else if (ins16[15:12] == T_BRANCH_COND) begin
         if (ins16[11:8] >= AL) begin
            dec_und   = 1'b1;
            dec_instr = '0;
         end else begin
            dec_instr = arm_branch(ins16[11:8], 1'b0, {{16{ins16[7]}}, ins16[7:0]});
         end
      end else if (ins16[15:11] == T_BRANCH_NOCOND) begin
         dec_instr = arm_branch(AL, 1'b0, {{13{ins16[10]}}, ins16[10:0]});
      end else if ((ins16[15:7] == T_BX) && (ins16[2:0] == 3'b000)) begin
         dec_instr = {3'b000, ARM_BX_BASE | {28'b0, ins16[6:3]}};
      end else if (is_pre) begin
         if (FUSE_BL != 0) begin
            dec_emit = 1'b0;
         end else begin
            dec_instr = arm_branch(AL, 1'b1, {{2{ins16[10]}}, ins16[10:0], 11'b0});
         end
      end else if (is_suf) begin
         if (FUSE_BL == 0) begin
            dec_instr = arm_branch(AL, 1'b1, {13'b0, ins16[10:0]});
         end else if (held) begin
            dec_instr = arm_branch(AL, 1'b1, {{2{held_hi[10]}}, held_hi, ins16[10:0]});
         end else begin
            dec_und   = 1'b1;
            dec_instr = '0;
         end
      end
   end

   // Output register next-value: flush beats stall, stall holds everything,
   // an orphaned prefix reports und at its own PC, otherwise an accepted
   // word is emitted and an idle cycle drops valid.
   always_comb begin
      instr_d = instr_q;
      valid_d = valid_q;
      und_d   = und_q;
      pc_d    = pc_q;
      if (i_clear_from_alu) begin
         valid_d = 1'b0;
         und_d   = 1'b0;
      end else if (!i_stall_from_decode) begin
         if (orphan) begin
            valid_d = 1'b1;
            und_d   = 1'b1;
            instr_d = '0;
            pc_d    = held_pc;
         end else if (accept) begin
            valid_d = dec_emit;
            und_d   = dec_und;
            if (dec_emit) begin
               instr_d = dec_instr;
               pc_d    = (held && is_suf) ? held_pc : i_pc;
            end
         end else begin
            valid_d = 1'b0;
            und_d   = 1'b0;
         end
      end
   end

   // Output registers, cleared by reset regardless of flush or stall.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         instr_q <= '0;
         valid_q <= 1'b0;
         und_q   <= 1'b0;
         pc_q    <= '0;
      end else begin
         instr_q <= instr_d;
         valid_q <= valid_d;
         und_q   <= und_d;
         pc_q    <= pc_d;
      end
   end

   assign o_instruction       = instr_q;
   assign o_instruction_valid = valid_q;
   assign o_und               = und_q;
   assign o_pc                = pc_q;

endmodule

// File: doc/zap_decode_thumb_seq.md
ZAP_DECODE_THUMB_SEQ -- requirements
Module: zap_decode_thumb_seq

Interface
REQ-001 Parameter T_BIT, default 5: CPSR bit index that selects Thumb state.
REQ-002 Parameter FUSE_BL, default 1: 1 fuses each BL prefix/suffix pair into one ARM BL; 0 emits each half separately.
REQ-003 Parameter PC_W, default 32: width of the PC sideband.
REQ-004 i_clk  in  1  single clock; all state is updated on the rising edge.
REQ-005 i_reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 i_instruction  in  32  fetched word; only [15:0] is used in Thumb state.
REQ-007 i_instruction_valid  in  1  i_instruction is valid this cycle.
REQ-008 i_pc  in  PC_W  PC of i_instruction.
REQ-009 i_cpsr_ff  in  32  current CPSR.
REQ-010 i_stall_from_decode  in  1  downstream stall.
REQ-011 i_clear_from_alu  in  1  pipeline flush.
REQ-012 o_stall  out  1  combinational; upstream holds i_instruction, i_instruction_valid and i_pc while o_stall=1.
REQ-013 o_instruction  out  35  registered ARM-format word; bit34=1 means the offset is in halfwords (x2).
REQ-014 o_instruction_valid, o_und  out  1 each  registered; o_und marks an undefined instruction.
REQ-015 o_pc  out  PC_W  registered PC of the emitted instruction.

Function
REQ-016 Latency SHALL be one cycle from an accepted input to a registered output.
REQ-017 An input is accepted when i_instruction_valid=1, o_stall=0, i_stall_from_decode=0 and i_clear_from_alu=0.
REQ-018 ARM state (i_cpsr_ff[T_BIT]=0): output {3'b0, i_instruction}, with o_und=0.
REQ-019 Thumb B<cond> (1101 cccc oooooooo), cccc<=1101: output {1,00,cccc,101,0,sext24(o[7:0])}.
REQ-020 Thumb B<cond> with cccc=1110 or 1111: output o_und=1.
REQ-021 Thumb B (11100, 11-bit offset): output {1,00,1110,101,0,sext24(o[10:0])}.
REQ-022 Thumb BX (010001110 H2 Rs 000): output {3'b0, 32'hE12FFF10 | {H2,Rs}}.
REQ-023 Thumb BL prefix (11110 hi[10:0]) with FUSE_BL=1: no output; store hi and i_pc; move state IDLE->HELD.
REQ-024 In state HELD, a BL suffix (11111 lo[10:0]) SHALL:
  - output {1,00,1110,101,1,sext24({hi,lo})};
  - set o_pc to the stored prefix PC;
  - return the state to IDLE.
REQ-025 In state HELD, any input other than a suffix, including a T-bit drop, SHALL:
  - output o_und=1 with o_pc = the stored prefix PC;
  - assert o_stall for that one cycle, so the input is not consumed;
  - return the state to IDLE.
REQ-026 Suffix received in state IDLE: output o_und=1.
REQ-027 With FUSE_BL=0:
  - prefix output: {1,00,1110,101,1,sext24(hi<<11)};
  - suffix output: {1,00,1110,101,1,24'(lo)};
  - no HELD state is used.
REQ-028 All other Thumb encodings: output {19'b0, i_instruction[15:0]}, with o_und=0.
REQ-029 While i_stall_from_decode=1, all outputs and internal state SHALL hold.
REQ-030 While i_stall_from_decode=1, o_stall SHALL equal 1.
REQ-031 i_clear_from_alu=1 SHALL, on the next edge:
  - set o_instruction_valid=0;
  - set state to IDLE and discard the held prefix.
REQ-032 i_clear_from_alu SHALL take priority over stall.
REQ-033 A cycle with no accepted input SHALL give o_instruction_valid=0 on the next edge.

Reset
REQ-034 While i_reset=0, at each edge, every output register SHALL be cleared and the state SHALL be IDLE.
REQ-035 Reset SHALL take priority over clear and stall.
REQ-036 A held prefix SHALL be lost on reset.

Structure
REQ-037 A shared package SHALL hold:
  - Thumb pattern constants (T_BRANCH_COND, T_BRANCH_NOCOND, T_BL_PRE, T_BL_SUF, T_BX);
  - condition codes (AL=1110);
  - the state encoding (IDLE, HELD).
REQ-038 Sub-module zap_thumb_bl_fuse SHALL contain the prefix register and the HELD FSM.
REQ-039 The rest of the block SHALL be combinational decode followed by an output register.

Verification
REQ-040 Conditional branch: Thumb, input 0xD0FE -> next cycle o_instruction={1,00,0000,101,0,24'hFFFFFE}, valid=1.
REQ-041 Fused BL: FUSE_BL=1, input 0xF000 at pc 0x100, then 0xF801 -> one output {1,00,1110,101,1,24'h000001}, o_pc=0x100; valid=0 the cycle after the prefix.
REQ-042 BX: input 0x4770 -> o_instruction=35'h0E12FFF1E.
REQ-043 Orphan prefix: input 0xF000 then 0x2001 ->
  - cycle 1: o_stall=1, then o_und=1 with the prefix PC;
  - next: 0x2001 emitted raw with o_und=0.
REQ-044 Stall and clear: hold stall 3 cycles -> outputs unchanged; then pulse clear while HELD -> valid=0, state IDLE, next suffix gives o_und=1.
REQ-045 ARM passthrough and reset: ARM state, input 0xE3A00001 -> o_instruction=35'h0E3A00001; i_reset=0 mid-HELD -> all outputs 0 on the next edge.
